// File: rtl/dcp_pkg.sv
// Shared encodings for the debug control processor run controller:
// stop causes, sequencer states and the command characters behind each mode.
package dcp_pkg;

    localparam byte CMD_STEP = "T";
    localparam byte CMD_RUN  = "G";

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_STEP = 3'd1,
        CAUSE_BP0  = 3'd2,
        CAUSE_BP1  = 3'd3,
        CAUSE_HALT = 3'd4,
        CAUSE_TMO  = 3'd5
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_CHK,
        ST_FIN
    } state_e;

    // Mode encodings reuse the command characters so a latched mode reads as the command.
    typedef enum logic [7:0] {
        MODE_STEP = CMD_STEP,
        MODE_RUN  = CMD_RUN
    } mode_e;

endpackage

// File: rtl/dcp_run_ctrl_if.sv
// Command/status bundle between the debug command logic and the CPU-clock sequencer.
interface dcp_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             step_req;
    logic             run_req;
    logic             halt_req;
    logic [1:0]       bp_en;
    logic [31:0]      bp0;
    logic [31:0]      bp1;
    logic [31:0]      pc_chk;
    logic             clk_cpu;
    logic             busy;
    logic             done;
    logic [2:0]       cause;
    logic [CNT_W-1:0] cyc_cnt;

    modport master (
        output step_req, run_req, halt_req, bp_en, bp0, bp1, pc_chk,
        input  clk_cpu, busy, done, cause, cyc_cnt
    );

    modport slave (
        input  step_req, run_req, halt_req, bp_en, bp0, bp1, pc_chk,
        output clk_cpu, busy, done, cause, cyc_cnt
    );
endinterface

// File: rtl/dcp_bp_cmp.sv
// Two-entry breakpoint comparator: flags which enabled breakpoint matches the next PC.
module dcp_bp_cmp (
    input  logic [1:0]  bp_en,
    input  logic [31:0] bp0,
    input  logic [31:0] bp1,
    input  logic [31:0] pc_chk,
    output logic        hit0,
    output logic        hit1
);

    assign hit0 = bp_en[0] && (pc_chk == bp0);
    assign hit1 = bp_en[1] && (pc_chk == bp1);

endmodule

// File: rtl/dcp_run_ctrl.sv
// CPU-clock sequencer: issues clk_cpu pulses for step/run commands and
// reports why sequencing stopped (step, breakpoint, halt or cycle budget).
module dcp_run_ctrl
    import dcp_pkg::*;
#(
    parameter int unsigned      HALF    = 2,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] MAX_CYC = {CNT_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rstn,
    dcp_run_ctrl_if.slave   bus
);

    localparam logic [7:0]       PH_LAST = 8'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    mode_e            mode_q;
    cause_e           cause_q;
    cause_e           stop_cause;
    logic [7:0]       ph_q;
    logic [CNT_W-1:0] cyc_cnt_q;
    logic             clk_cpu_q;
    logic             busy_q;
    logic             done_q;
    logic             hit0;
    logic             hit1;

    dcp_bp_cmp u_bp_cmp (
        .bp_en  (bus.bp_en),
        .bp0    (bus.bp0),
        .bp1    (bus.bp1),
        .pc_chk (bus.pc_chk),
        .hit0   (hit0),
        .hit1   (hit1)
    );

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        stop_cause = CAUSE_NONE;
        if (mode_q == MODE_STEP)        stop_cause = CAUSE_STEP;
        else if (bus.halt_req)          stop_cause = CAUSE_HALT;
        else if (hit0)                  stop_cause = CAUSE_BP0;
        else if (hit1)                  stop_cause = CAUSE_BP1;
        else if (cyc_cnt_q == MAX_CYC)  stop_cause = CAUSE_TMO;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_STEP;
            cause_q   <= CAUSE_NONE;
            ph_q      <= 8'd0;
            cyc_cnt_q <= '0;
            clk_cpu_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.step_req || bus.run_req) begin
                        mode_q    <= bus.step_req ? MODE_STEP : MODE_RUN;
                        state_q   <= ST_HI;
                        clk_cpu_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cause_q   <= CAUSE_NONE;
                        cyc_cnt_q <= '0;
                        ph_q      <= 8'd0;
                    end
                end
                ST_HI: begin
                    if (ph_q == PH_LAST) begin
                        state_q   <= ST_LO;
                        clk_cpu_q <= 1'b0;
                        ph_q      <= 8'd0;
                        // Saturate rather than wrap so a long run never reports a small count.
                        if (cyc_cnt_q != {CNT_W{1'b1}}) cyc_cnt_q <= cyc_cnt_q + CNT_ONE;
                    end else begin
                        ph_q <= ph_q + 8'd1;
                    end
                end
                ST_LO: begin
                    if (ph_q == PH_LAST) begin
                        state_q <= ST_CHK;
                        ph_q    <= 8'd0;
                    end else begin
                        ph_q <= ph_q + 8'd1;
                    end
                end
                ST_CHK: begin
                    if (stop_cause != CAUSE_NONE) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        cause_q <= stop_cause;
                    end else begin
                        state_q   <= ST_HI;
                        clk_cpu_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    clk_cpu_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_cpu = clk_cpu_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cause   = cause_q;
    assign bus.cyc_cnt = cyc_cnt_q;

endmodule
